booth_seq_multiplier: RTL
=========================

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  operand pair and mode presented.
REQ-005 Port in_ready  output  1  block can accept operands.
REQ-006 Port multiplicand  input  WIDTH  operand A.
REQ-007 Port multiplier  input  WIDTH  operand B.
REQ-008 Port signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-009 Port out_valid  output  1  product valid.
REQ-010 Port out_ready  input  1  consumer accepts product.
REQ-011 Port product  output  2*WIDTH  result A*B, signed or unsigned per captured mode.
REQ-012 Port busy  output  1  high while state is not IDLE.

Function
REQ-013 FSM states: IDLE, CALC, DONE; IDLE->CALC on in_valid&&in_ready; CALC->DONE when step counter reaches WIDTH; DONE->IDLE on out_ready.
REQ-014 in_ready = (state==IDLE), combinational from state only; no operand accepted in CALC or DONE.
REQ-015 On acceptance: capture operands and signed_mode; extend each to WIDTH+1 bits (sign-extend if signed_mode, zero-extend otherwise); clear accumulator, Booth guard bit and step counter.
REQ-016 CALC performs exactly one radix-2 Booth step per cycle, WIDTH+1 steps total, counter 0..WIDTH.
REQ-017 Booth step: pair {current multiplier bit, guard bit}: 10 -> add negated extended multiplicand to upper half; 01 -> add extended multiplicand; 00/11 -> no add; then arithmetic right shift of full accumulator by 1; guard bit <= current bit.
REQ-018 Accumulator width 2*WIDTH+2 plus guard; upper-half add is modulo its width; product = low 2*WIDTH bits of final accumulator.
REQ-019 Latency fixed, data-independent: out_valid high on the cycle after the (WIDTH+1)th step, i.e. WIDTH+2 rising edges after the acceptance edge.
REQ-020 product and out_valid held stable in DONE until out_ready high; out_ready ignored outside DONE.
REQ-021 out_valid&&out_ready -> IDLE next cycle, in_ready high that cycle; minimum initiation interval WIDTH+3 cycles.
REQ-022 Input changes on multiplicand, multiplier, signed_mode after acceptance have no effect on the result.
REQ-023 Most-negative operands in signed mode produce the exact product (no overflow, e.g. WIDTH=8: -128*-128 = 16384).
REQ-024 product reads as 0 whenever state is not DONE.

Reset
REQ-025 rst high at a clock edge forces IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator, counter and captured operands cleared.
REQ-026 rst during CALC or DONE abandons the operation; no out_valid is produced for it.
REQ-027 rst takes priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Shared package booth_pkg holds: state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2), Booth pair encodings (ADD=2'b01, SUB=2'b10), default WIDTH.
REQ-029 One sub-module booth_step: purely combinational, parameter WIDTH, takes accumulator, guard bit, extended multiplicand, returns next accumulator and guard; FSM and registers remain in booth_seq_multiplier.

Verification
REQ-030 WIDTH=8, signed, A=3, B=-5, out_ready=1 -> out_valid exactly 10 edges after acceptance, product=16'hFFF1 (-15), one cycle pulse, then in_ready=1.
REQ-031 WIDTH=8, unsigned, A=255, B=255 -> product=16'hFE01 (65025); same inputs signed -> product=16'h0001.
REQ-032 WIDTH=8, signed, A=-128, B=-128, out_ready held 0 for 5 cycles after out_valid -> product=16'h4000 held stable, in_valid pulses ignored (in_ready=0), completes on out_ready.
REQ-033 rst asserted on 4th CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0; following op A=7, B=6 unsigned -> product=42.
REQ-034 Random operands, both modes, WIDTH in {4,8,16}, random in_valid/out_ready gaps, operands toggled during CALC -> every product equals reference multiply of captured values, no lost or duplicated results.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encodings, Booth pair encodings and default width
package booth_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth add/subtract-and-shift step
module booth_step import booth_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH+1:0] acc,
  input  logic               guard,
  input  logic [WIDTH:0]     mcand,
  output logic [2*WIDTH+1:0] acc_next,
  output logic               guard_next
);
  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;
  logic [1:0]     pair;
  always_comb begin
    upper      = acc[2*WIDTH+1:WIDTH+1];
    pair       = {acc[0], guard};
    sum        = pair == SUB ? upper - mcand : pair == ADD ? upper + mcand : upper;
    acc_next   = {sum[WIDTH], sum, acc[WIDTH:1]};
    guard_next = acc[0];
  end
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth multiplier, signed or unsigned, valid/ready handshakes
module booth_seq_multiplier import booth_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int AW = 2*WIDTH + 2;
  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, acc_step;
  logic            guard_q, guard_d, guard_step;
  logic [WIDTH:0]  mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_q),
    .guard      (guard_q),
    .mcand      (mcand_q),
    .acc_next   (acc_step),
    .guard_next (guard_step)
  );
  // Steps run at counts 0..WIDTH; the extra count settles the result so latency is WIDTH+2
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    guard_d = guard_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        mcand_d = {signed_mode & multiplicand[WIDTH-1], multiplicand};
        acc_d   = {{(WIDTH+1){1'b0}}, signed_mode & multiplier[WIDTH-1], multiplier};
        guard_d = 1'b0;
        cnt_d   = '0;
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH + 1)) state_d = DONE;
        else begin
          acc_d   = acc_step;
          guard_d = guard_step;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      guard_q <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      guard_q <= guard_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign product   = state_q == DONE ? acc_q[2*WIDTH-1:0] : '0;
endmodule
